// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions used by the receiver (and the transmitter side).
//   rx_state_e  : receiver FSM states
//   PRESC_*     : supported oversampling ratios
//   PAR_*       : PAR_TYP encoding (0 = even, 1 = odd)
//   legal_presc : maps any oversampling ratio onto a supported one
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

    localparam int PRESC_8  = 8;
    localparam int PRESC_16 = 16;
    localparam int PRESC_32 = 32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Unsupported ratios fall back to 8.
    function automatic int legal_presc(input int p);
        return (p == PRESC_16 || p == PRESC_32) ? p : PRESC_8;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// uart_rx_edge_bit_cnt: oversampling edge counter and data-bit counter for uart_rx.
//   clk, rst_n : receiver clock, asynchronous active-low reset
//   start      : this cycle is edge 0 of a start bit; latches the prescale
//   active     : the frame continues next cycle; when low the edge counter clears
//   bit_en     : advance the bit counter at each last edge
//   prescale   : raw oversampling ratio, illegal values act as 8
//   bit_cnt    : data bits completed in the current frame
//   mid        : decision point, edge_cnt == P/2
//   pre_last   : edge_cnt == P-2
//   last       : edge_cnt == P-1
module uart_rx_edge_bit_cnt
    import uart_pkg::*;
#(
    parameter int PRESC_W = 6,
    parameter int BIT_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               active,
    input  logic               bit_en,
    input  logic [PRESC_W-1:0] prescale,
    output logic [BIT_W-1:0]   bit_cnt,
    output logic               mid,
    output logic               pre_last,
    output logic               last
);

    logic [PRESC_W-1:0] p_q, p_d, edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;

    // The start cycle is edge 0, so the counter jumps straight to 1.
    always_comb begin
        p_d        = start ? PRESC_W'(legal_presc(int'(prescale))) : p_q;
        edge_cnt_d = start ? PRESC_W'(1) : (!active || last) ? '0 : edge_cnt_q + PRESC_W'(1);
        bit_cnt_d  = start ? '0 : (bit_en && last) ? bit_cnt_q + BIT_W'(1) : bit_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q        <= PRESC_W'(PRESC_8);
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            p_q        <= p_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign bit_cnt  = bit_cnt_q;
    assign mid      = edge_cnt_q == (p_q >> 1);
    assign pre_last = edge_cnt_q == p_q - PRESC_W'(2);
    assign last     = edge_cnt_q == p_q - PRESC_W'(1);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (start, DATA_WIDTH data bits LSB first, optional parity, 1 stop).
//   CLK        : receiver clock, Prescale x baud
//   RST        : asynchronous active-low reset
//   RX_IN      : serial line, idle high
//   PAR_EN     : frame carries a parity bit
//   PAR_TYP    : 0 = even, 1 = odd
//   Prescale   : oversampling ratio 8/16/32 (others act as 8), latched at the start edge
//   P_DATA     : last good word, held until the next good frame
//   data_valid : one-cycle strobe when P_DATA updates
//   par_err    : parity mismatch on the current/last frame
//   stp_err    : stop bit sampled 0 on the current/last frame
// Build option UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote over edges P/2-2..P/2 instead of a
// single sample taken at P/2-1.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESC_W-1:0]    Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    rx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, p_data_q, p_data_d;
    logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic                  par_err_q, par_err_d, stp_err_q, stp_err_d, valid_q, valid_d;
    logic                  start, active, mid, pre_last, last, bit_val;
    logic [BIT_W-1:0]      bit_cnt;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] samp_q, samp_d;
    assign samp_d  = {samp_q[0], RX_IN};
    assign bit_val = (samp_q[1] & samp_q[0]) | (samp_q[1] & RX_IN) | (samp_q[0] & RX_IN);
`else
    logic samp_q, samp_d;
    assign samp_d  = RX_IN;
    assign bit_val = samp_q;
`endif

    uart_rx_edge_bit_cnt #(.PRESC_W(PRESC_W), .BIT_W(BIT_W)) u_cnt (
        .clk      (CLK),
        .rst_n    (RST),
        .start    (start),
        .active   (active),
        .bit_en   (state_q == DATA),
        .prescale (Prescale),
        .bit_cnt  (bit_cnt),
        .mid      (mid),
        .pre_last (pre_last),
        .last     (last)
    );

    assign active = state_d != IDLE;

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        shift_d   = shift_q;
        p_data_d  = p_data_q;
        valid_d   = 1'b0;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        par_err_d = par_err_q;
        stp_err_d = stp_err_q;
        case (state_q)
            IDLE: begin
                state_d = RX_IN ? IDLE : START;
                start   = !RX_IN;
            end
            START: state_d = (mid && bit_val) ? IDLE : last ? DATA : START;
            DATA: begin
                shift_d = mid ? {bit_val, shift_q[DATA_WIDTH-1:1]} : shift_q;
                if (last && bit_cnt == BIT_W'(DATA_WIDTH - 1))
                    state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                par_err_d = mid ? bit_val != (^shift_q ^ (par_typ_q != PAR_EVEN)) : par_err_q;
                state_d   = last ? STOP : PARITY;
            end
            STOP: begin
                stp_err_d = mid ? !bit_val : stp_err_q;
                // Armed one edge early so the strobe and P_DATA land on the final stop edge.
                if (pre_last && !par_err_q && !stp_err_q) begin
                    p_data_d = shift_q;
                    valid_d  = 1'b1;
                end
                // A low line on the final stop edge is edge 0 of a back-to-back frame.
                if (last) begin
                    state_d = RX_IN ? IDLE : START;
                    start   = !RX_IN;
                end
            end
            default: state_d = IDLE;
        endcase
        if (start) begin
            par_en_d  = PAR_EN;
            par_typ_d = PAR_TYP;
            par_err_d = 1'b0;
            stp_err_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            p_data_q  <= '0;
            valid_q   <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            samp_q    <= '1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            p_data_q  <= p_data_d;
            valid_q   <= valid_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
            samp_q    <= samp_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx;

    typedef struct {
        int p_in;
        bit pe;
        bit pt;
    } cfg_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic [7:0] P_DATA;
    logic       data_valid, par_err, stp_err;

    int         compared = 0;
    int         mismatched = 0;
    logic [7:0] exp_pdata = 8'h00;

    uart_rx dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 CLK = ~CLK;

    function automatic int eff_p(input int p_in);
        return (p_in == 16 || p_in == 32) ? p_in : 8;
    endfunction

    function automatic int frame_len(input cfg_t c);
        return (c.pe ? 11 : 10) * eff_p(c.p_in);
    endfunction

    // Line level in frame cycle k: start, data LSB first, parity, stop.
    // The final stop cycle is high unless the next frame starts there (early).
    function automatic logic line_bit(input logic [7:0] d, input cfg_t c, input bit flip,
                                      input bit stop_bit, input bit early, input int k);
        int slot;
        slot = k / eff_p(c.p_in);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot-1];
        if (c.pe && slot == 9) return (^d) ^ c.pt ^ flip;
        if (k == frame_len(c) - 1) return !early;
        return stop_bit;
    endfunction

    function automatic cfg_t rand_cfg();
        cfg_t c;
        case ($urandom_range(0, 3))
            0: c.p_in = 8;
            1: c.p_in = 16;
            2: c.p_in = 32;
            default: c.p_in = int'($urandom_range(0, 63));
        endcase
        c.pe = 1'($urandom);
        c.pt = 1'($urandom);
        return c;
    endfunction

    task automatic send_frame(input logic [7:0] d, input cfg_t c, input cfg_t nc, input bit flip,
                              input bit stop_bit, input bit early, input bit skip0,
                              input bit scramble, input int chg_p, input string name);
        int p, n, stop_slot;
        bit exp_par, exp_stp, good;
        p = eff_p(c.p_in);
        n = frame_len(c);
        stop_slot = c.pe ? 10 : 9;
        exp_par = c.pe && flip;
        exp_stp = !stop_bit;
        good = !exp_par && !exp_stp;
        for (int k = skip0 ? 1 : 0; k < n; k++) begin
            @(posedge CLK);
            #1;
            RX_IN = line_bit(d, c, flip, stop_bit, early, k);
            if (k == 0) begin
                Prescale = 6'(c.p_in);
                PAR_EN = c.pe;
                PAR_TYP = c.pt;
            end else if (early && k == n - 1) begin
                Prescale = 6'(nc.p_in);
                PAR_EN = nc.pe;
                PAR_TYP = nc.pt;
            end else if (scramble) begin
                Prescale = 6'($urandom_range(0, 63));
                PAR_EN = 1'($urandom);
                PAR_TYP = 1'($urandom);
            end
            if (chg_p != 0 && k >= 20 && !(early && k == n - 1)) Prescale = 6'(chg_p);
            @(negedge CLK);
            compared++;
            if (data_valid !== (good && k == n - 1)) begin
                mismatched++;
                $display("FAIL %s data_valid cycle %0d: got %b expected %b", name, k, data_valid, good && k == n - 1);
            end
            if (k == 1) begin
                compared++;
                if ({par_err, stp_err} !== 2'b00) begin
                    mismatched++;
                    $display("FAIL %s flags_clear: got par=%b stp=%b expected 0 0", name, par_err, stp_err);
                end
            end
            if (c.pe && (k == 9 * p + p / 2 || k == 9 * p + p / 2 + 1)) begin
                compared++;
                if (par_err !== (exp_par && k == 9 * p + p / 2 + 1)) begin
                    mismatched++;
                    $display("FAIL %s par_err cycle %0d: got %b expected %b", name, k, par_err, exp_par && k == 9 * p + p / 2 + 1);
                end
            end
            if (k == stop_slot * p + p / 2 || k == stop_slot * p + p / 2 + 1) begin
                compared++;
                if (stp_err !== (exp_stp && k == stop_slot * p + p / 2 + 1)) begin
                    mismatched++;
                    $display("FAIL %s stp_err cycle %0d: got %b expected %b", name, k, stp_err, exp_stp && k == stop_slot * p + p / 2 + 1);
                end
            end
            if (k == n - 1) begin
                if (good) exp_pdata = d;
                compared++;
                if (P_DATA !== exp_pdata || par_err !== exp_par || stp_err !== exp_stp) begin
                    mismatched++;
                    $display("FAIL %s end_of_frame: got data=%h par=%b stp=%b expected data=%h par=%b stp=%b",
                             name, P_DATA, par_err, stp_err, exp_pdata, exp_par, exp_stp);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        compared += 4;
        if (P_DATA !== 8'h00) begin mismatched++; $display("FAIL reset P_DATA: got %h expected 00", P_DATA); end
        if (data_valid !== 1'b0) begin mismatched++; $display("FAIL reset data_valid: got %b expected 0", data_valid); end
        if (par_err !== 1'b0) begin mismatched++; $display("FAIL reset par_err: got %b expected 0", par_err); end
        if (stp_err !== 1'b0) begin mismatched++; $display("FAIL reset stp_err: got %b expected 0", stp_err); end
        @(posedge CLK);
        #1 RST = 1'b1;
    endtask

    task automatic test_basic();
        cfg_t c = '{p_in: 8, pe: 1'b1, pt: 1'b0};
        send_frame(8'hA5, c, c, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "basic_a5");
    endtask

    task automatic test_parity_err();
        cfg_t c = '{p_in: 16, pe: 1'b1, pt: 1'b1};
        send_frame(8'h3C, c, c, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, "parity_err_3c");
    endtask

    task automatic test_back_to_back();
        cfg_t c = '{p_in: 32, pe: 1'b0, pt: 1'b0};
        cfg_t c8 = '{p_in: 8, pe: 1'b1, pt: 1'b1};
        send_frame(8'h55, c, c, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, "stop_err_55");
        send_frame(8'h0F, c, c, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, "b2b_0f");
        send_frame(8'h96, c8, c8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "b2b_idle_96");
        send_frame(8'h69, c8, c8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, "b2b_early_69");
        send_frame(8'hE1, c8, c8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, "b2b_early_e1");
    endtask

    task automatic test_glitch();
        cfg_t c;
        int p, len;
        for (int g = 0; g < 5; g++) begin
            c = rand_cfg();
            if (g == 0) c = '{p_in: 16, pe: 1'b0, pt: 1'b0};
            p = eff_p(c.p_in);
            len = (g == 0) ? 3 : int'($urandom_range(1, p / 2 - 1));
            for (int k = 0; k <= p / 2; k++) begin
                @(posedge CLK);
                #1;
                RX_IN = (k < len) ? 1'b0 : 1'b1;
                if (k == 0) begin
                    Prescale = 6'(c.p_in);
                    PAR_EN = c.pe;
                    PAR_TYP = c.pt;
                end
                @(negedge CLK);
                compared++;
                if (data_valid !== 1'b0 || par_err !== 1'b0 || stp_err !== 1'b0) begin
                    mismatched++;
                    $display("FAIL glitch_%0d cycle %0d: got dv=%b par=%b stp=%b expected 0 0 0", g, k, data_valid, par_err, stp_err);
                end
            end
            // The next start edge lands exactly on the IDLE re-entry cycle.
            send_frame((g == 0) ? 8'h81 : 8'($urandom), c, c, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "after_glitch");
        end
    endtask

    task automatic test_presc_change();
        cfg_t c8 = '{p_in: 8, pe: 1'b1, pt: 1'b0};
        cfg_t c32 = '{p_in: 32, pe: 1'b1, pt: 1'b0};
        send_frame(8'hC3, c8, c8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32, "presc_chg_c3");
        send_frame(8'h5A, c32, c32, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "presc_32_5a");
    endtask

    task automatic test_reset_midframe();
        cfg_t c = '{p_in: 8, pe: 1'b1, pt: 1'b0};
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK);
            #1;
            RX_IN = line_bit(8'h3A, c, 1'b0, 1'b1, 1'b0, k);
            if (k == 0) begin
                Prescale = 6'(c.p_in);
                PAR_EN = c.pe;
                PAR_TYP = c.pt;
            end
            @(negedge CLK);
            compared++;
            if (data_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL pre_reset data_valid cycle %0d: got %b expected 0", k, data_valid);
            end
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        RX_IN = 1'b1;
        exp_pdata = 8'h00;
        #1;
        compared++;
        if ({P_DATA, data_valid, par_err, stp_err} !== 11'd0) begin
            mismatched++;
            $display("FAIL midframe_reset outputs: got data=%h dv=%b par=%b stp=%b expected all 0", P_DATA, data_valid, par_err, stp_err);
        end
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        RX_IN = 1'b0;
        send_frame(8'h7E, c, c, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, "after_reset_7e");
    endtask

    task automatic test_random();
        cfg_t c, nc;
        bit early, skip;
        skip = 1'b0;
        c = rand_cfg();
        for (int i = 0; i < 30; i++) begin
            nc = rand_cfg();
            early = ($urandom_range(0, 2) == 0);
            send_frame(8'($urandom), c, nc, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                       early, skip, 1'($urandom), 0, "random");
            skip = early;
            if (!early) repeat ($urandom_range(0, 5)) @(posedge CLK);
            c = nc;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_err();
        test_back_to_back();
        test_glitch();
        test_presc_change();
        test_reset_midframe();
        test_random();
        repeat (4) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver, the stage directly downstream of the UART transmitter on the serial link. Converts a one-wire asynchronous frame (start bit, DATA_WIDTH data bits LSB-first, optional parity bit, one stop bit) back into a parallel word with a one-cycle valid strobe. It flags parity and stop-bit errors. It runs on the RX clock domain at Prescale times the bit rate and delivers words to the register/command layer.

## Interface
- DATA_WIDTH, 8, data bits per frame
- PRESC_W, 6, width of the Prescale input
- CLK  in  1  receiver clock, Prescale × baud
- RST  in  1  asynchronous, active-low reset
- RX_IN  in  1  serial line, idle high
- PAR_EN  in  1  1 = frame carries a parity bit
- PAR_TYP  in  1  0 = even, 1 = odd
- Prescale  in  PRESC_W  oversampling ratio; legal values are 8, 16 and 32
- P_DATA  out  DATA_WIDTH  last good received word, held until the next good frame
- data_valid  out  1  one-cycle strobe, asserted when P_DATA updates
- par_err  out  1  parity mismatch on the current/last frame
- stp_err  out  1  stop bit sampled 0 on the current/last frame

## Operation
- Reset (RST=0, asynchronous): state IDLE, all counters 0, P_DATA=0, data_valid=0, par_err=0, stp_err=0.
- Per-bit edge counter `edge_cnt` runs 0..P-1. A bit counter tracks data bits.
- P, PAR_EN and PAR_TYP are latched in the cycle the start edge is detected, and are held for the whole frame. Changing these inputs mid-frame has no effect.
- Illegal Prescale values are treated as 8.
- Bit decision is made at edge_cnt = P/2.
- State machine:
  - IDLE: on RX_IN=0, this cycle is edge 0 of the start bit → START.
  - START: at the decision point, if the sampled value is 1 it is a glitch → IDLE, with no flags and no strobe. Otherwise, at edge P-1 → DATA.
  - DATA: shift the sample into bit[n] at the decision point, LSB first. After bit DATA_WIDTH-1 reaches edge P-1, go to PARITY if PAR_EN=1, else to STOP.
  - PARITY: the expected bit is ^data XOR PAR_TYP. par_err is set or cleared at the decision point. At edge P-1 → STOP.
  - STOP: stp_err = ~sample at the decision point. At edge P-1:
    - if par_err=0 and stp_err=0, load P_DATA and pulse data_valid;
    - then go to START if RX_IN=0 in that cycle (back-to-back frame, edge 0), else go to IDLE.
- par_err and stp_err hold until cleared at the next frame's START entry.
- A bad frame never updates P_DATA.

## Timing
- Frame length is 10·P cycles without parity and 11·P cycles with parity. Cycle 0 is the start-detect cycle.
- data_valid is high exactly in cycle 11·P-1 (parity) or 10·P-1 (no parity). P_DATA is registered and valid in that same cycle.
- par_err is visible in the cycle after the parity decision point. stp_err is visible in the cycle after the stop decision point.
- A back-to-back start is accepted with zero idle cycles between frames.
- Reset mid-frame aborts the frame with no strobe. The receiver is ready for a start edge in the first cycle after reset is released.
- A glitch shorter than P/2 cycles is rejected, and IDLE is re-entered at edge P/2+1.

## Configuration
- UART_RX_MAJORITY_VOTE_EN:
  - Defined: RX_IN is sampled at edges P/2-2, P/2-1 and P/2. The bit value is the 2-of-3 majority, decided at edge P/2.
  - Undefined: the bit value is RX_IN sampled at edge P/2-1, registered and used at edge P/2.
  - Frame timing and strobe position are identical in both builds.

## Structure
- Shared package uart_pkg:
  - rx state enum (IDLE, START, DATA, PARITY, STOP);
  - supported-prescale constants 8/16/32;
  - PAR_TYP encoding constants (EVEN=0, ODD=1), shared with the transmitter side.
- One sub-module, uart_rx_edge_bit_cnt. It provides edge_cnt and bit_cnt, plus the decision-point and last-edge pulses derived from latched P.
- FSM, sampler, deserializer and checkers stay in the top level.

## Test plan
- P=8, PAR_EN=1, even, send 0xA5 with parity 0 → data_valid at cycle 87, P_DATA=0xA5, par_err=0, stp_err=0.
- P=16, PAR_EN=1, odd, send 0x3C with parity 0 (wrong) → par_err=1, no data_valid, P_DATA keeps its previous value.
- P=32, PAR_EN=0, send 0x55 with stop bit 0 → stp_err=1 at cycle 305, no strobe. Then send a good 0x0F back-to-back → stp_err clears at START and 0x0F is strobed.
- P=16, RX_IN low for 3 cycles then high → return to IDLE, no flags, no strobe. A following valid 0x81 frame is received correctly.
- Prescale changed from 8 to 32 at cycle 20 of a P=8 frame (0xC3) → frame decoded at P=8, and the next frame uses P=32.
- RST asserted at cycle 40 of a P=8 frame → all outputs 0 immediately, no strobe. The next frame 0x7E is received correctly.
